// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between the CPU control path and the data memory controller.
interface data_memory_ctrl_if #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned ADDR_W = 24
);
    logic              Req;
    logic              Ready;
    logic [ADDR_W-1:0] Address;
    logic [DATA_W-1:0] WriteData;
    logic              MemWrite;
    logic              MemRead;
    logic [1:0]        Size;
    logic              Unsigned;
    logic [DATA_W-1:0] ReadData;
    logic              Done;
    logic              Fault;

    modport master (
        output Req, Address, WriteData, MemWrite, MemRead, Size, Unsigned,
        input  Ready, ReadData, Done, Fault
    );

    modport slave (
        input  Req, Address, WriteData, MemWrite, MemRead, Size, Unsigned,
        output Ready, ReadData, Done, Fault
    );
endinterface

// File: rtl/data_memory_ctrl.sv
// Byte-addressed data memory with sized, endian-selectable loads/stores, a request/ready
// handshake, optional wait states and a fault response for illegal or out-of-range accesses.
module data_memory_ctrl #(
    parameter int unsigned DATA_W      = 24,
    parameter int unsigned ADDR_W      = 24,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned BIG_ENDIAN  = 1
) (
    input logic               Clock,
    input logic               Reset_n,
    data_memory_ctrl_if.slave bus
);
    localparam int unsigned NB = DATA_W / 8;
    localparam int unsigned MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              wr_q, rd_q, uns_q;
    logic [1:0]        size_q;
    logic [DATA_W-1:0] rdata_q;
    logic              done_q, fault_q;

    logic [7:0]        mem [DEPTH];

    logic              accept;
    int unsigned       nbytes;
    logic [ADDR_W:0]   end_addr;
    logic              fault;
    logic [DATA_W-1:0] field;
    logic [DATA_W-1:0] load_val;

    // Field byte carried by the k-th memory byte of an n-byte access.
    function automatic int unsigned lane(input int unsigned k, input int unsigned n);
        return (BIG_ENDIAN != 0) ? (n - 1 - k) : k;
    endfunction

    // A request with neither qualifier set is a no-op and is not accepted.
    assign accept = (state_q == StIdle) && bus.Req && (bus.MemRead || bus.MemWrite);

    // Access size decode and fault detection on the held request.
    always_comb begin
        nbytes = NB;
        unique case (size_q)
            2'b00:   nbytes = 1;
            2'b01:   nbytes = 2;
            default: nbytes = NB;
        endcase
        // One extra bit so accesses near the top of the address space cannot wrap.
        end_addr = {1'b0, addr_q} + (ADDR_W+1)'(nbytes);
        fault    = (size_q == 2'b11) || (rd_q && wr_q) || (end_addr > (ADDR_W+1)'(DEPTH));
    end

    // Assemble the load field from memory and extend it to the full word.
    always_comb begin
        field = '0;
        for (int unsigned k = 0; k < NB; k++) begin
            if (k < nbytes) begin
                field[8*lane(k, nbytes) +: 8] = mem[MW'(addr_q + ADDR_W'(k))];
            end
        end
        load_val = field;
        unique case (size_q)
            2'b00:   load_val = uns_q ? DATA_W'(field[7:0])
                                      : {{(DATA_W-8){field[7]}}, field[7:0]};
            2'b01:   load_val = uns_q ? DATA_W'(field[15:0])
                                      : {{(DATA_W-16){field[15]}}, field[15:0]};
            default: load_val = field;
        endcase
    end

    // FSM next state and wait-state counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (WAIT_STATES > 0) begin
                        state_d = StWait;
                        cnt_d   = 4'(WAIT_STATES - 1);
                    end else begin
                        state_d = StResp;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM state, counter and request holding registers.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q  <= bus.Address;
                wdata_q <= bus.WriteData;
                wr_q    <= bus.MemWrite;
                rd_q    <= bus.MemRead;
                size_q  <= bus.Size;
                uns_q   <= bus.Unsigned;
            end
        end
    end

    // Response registers: one-cycle Done/Fault, ReadData updated on loads and faults.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            rdata_q <= '0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            done_q  <= (state_q == StResp);
            fault_q <= (state_q == StResp) && fault;
            if (state_q == StResp) begin
                if (fault) begin
                    rdata_q <= '0;
                end else if (rd_q) begin
                    rdata_q <= load_val;
                end
            end
        end
    end

    // Store path: bytes land only on the RESP exit edge, so a reset mid-access writes nothing.
    always_ff @(posedge Clock) begin
        if ((state_q == StResp) && wr_q && !rd_q && !fault) begin
            for (int unsigned k = 0; k < NB; k++) begin
                if (k < nbytes) begin
                    mem[MW'(addr_q + ADDR_W'(k))] <= wdata_q[8*lane(k, nbytes) +: 8];
                end
            end
        end
    end

    assign bus.Ready    = (state_q == StIdle);
    assign bus.ReadData = rdata_q;
    assign bus.Done     = done_q;
    assign bus.Fault    = fault_q;
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: three instances (big-endian, little-endian, three wait states)
// driven from a shared stimulus bus, with a vector table plus hand-written timing sequences.
module tb_data_memory_ctrl;
    localparam int DW = 24;
    localparam int AW = 24;
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    logic          Clock   = 1'b0;
    logic          Reset_n = 1'b1;
    logic [2:0]    req;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          mw, mr, uns;
    logic [1:0]    size;
    logic [2:0]    rdy, done, flt;
    logic [DW-1:0] rdat [3];

    int total = 0;
    int bad   = 0;

    always #5 Clock = ~Clock;

    // 0: big-endian, no wait; 1: little-endian, no wait; 2: big-endian, 3 wait states.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        data_memory_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
        assign bus.Req       = req[g];
        assign bus.Address   = addr;
        assign bus.WriteData = wdata;
        assign bus.MemWrite  = mw;
        assign bus.MemRead   = mr;
        assign bus.Size      = size;
        assign bus.Unsigned  = uns;
        assign rdy[g]        = bus.Ready;
        assign done[g]       = bus.Done;
        assign flt[g]        = bus.Fault;
        assign rdat[g]       = bus.ReadData;

        data_memory_ctrl #(
            .DATA_W     (DW),
            .ADDR_W     (AW),
            .DEPTH      (64),
            .WAIT_STATES((g == 2) ? 3 : 0),
            .BIG_ENDIAN ((g == 1) ? 0 : 1)
        ) dut (
            .Clock  (Clock),
            .Reset_n(Reset_n),
            .bus    (bus)
        );
    end

    typedef struct {
        int          d;
        logic        w, r;
        logic [1:0]  sz;
        logic        u;
        logic [23:0] a, wd;
        logic        crd;
        logic [23:0] erd;
        logic        ef;
    } vec_t;

    vec_t v[$];

    function automatic void add(int d, logic w, logic r, logic [1:0] sz, logic u,
                                logic [23:0] a, logic [23:0] wd, logic crd,
                                logic [23:0] erd, logic ef);
        vec_t x;
        x.d = d; x.w = w; x.r = r; x.sz = sz; x.u = u; x.a = a; x.wd = wd;
        x.crd = crd; x.erd = erd; x.ef = ef;
        v.push_back(x);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at posedge+1 right after an accept edge; lat = edges until Done is seen.
    task automatic wait_done(input int d, output int lat);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge Clock);
            #1;
            if (done[d]) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic access(input int d, input logic w, input logic r, input logic [1:0] sz,
                          input logic u, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          output logic [DW-1:0] rd, output logic f, output int lat);
        addr = a; wdata = wd; mw = w; mr = r; size = sz; uns = u;
        req = '0;
        req[d] = 1'b1;
        check($sformatf("ready_before_req d%0d", d), {31'd0, rdy[d]}, 32'd1);
        @(posedge Clock);
        #1;
        req = '0;
        wait_done(d, lat);
        rd = rdat[d];
        f  = flt[d];
    endtask

    logic [DW-1:0] rd;
    logic          f;
    int            lat;
    int            cnt;

    initial begin
        req = '0; addr = '0; wdata = '0; mw = 1'b0; mr = 1'b0; size = SZ_W; uns = 1'b0;
        #2 Reset_n = 1'b0;
        @(posedge Clock);
        #1;
        for (int g = 0; g < 3; g++) begin
            check($sformatf("rst_ready d%0d", g), {31'd0, rdy[g]}, 32'd1);
            check($sformatf("rst_done d%0d", g), {31'd0, done[g]}, 32'd0);
            check($sformatf("rst_fault d%0d", g), {31'd0, flt[g]}, 32'd0);
            check($sformatf("rst_rdata d%0d", g), {8'd0, rdat[g]}, 32'd0);
        end
        Reset_n = 1'b1;
        @(posedge Clock);
        #1;

        // d  w  r  size  u  addr   wdata       crd erd        fault
        add(0, 1, 0, SZ_W, 0, 24'd5,  24'hA1B2C3, 0, 24'h000000, 0);
        add(0, 0, 1, SZ_W, 0, 24'd5,  24'h000000, 1, 24'hA1B2C3, 0);
        add(0, 0, 1, SZ_B, 0, 24'd6,  24'h000000, 1, 24'hFFFFB2, 0);
        add(0, 0, 1, SZ_B, 1, 24'd6,  24'h000000, 1, 24'h0000B2, 0);
        add(0, 0, 1, SZ_H, 0, 24'd5,  24'h000000, 1, 24'hFFA1B2, 0);
        add(0, 0, 1, SZ_H, 1, 24'd6,  24'h000000, 1, 24'h00B2C3, 0);
        add(0, 0, 1, SZ_B, 0, 24'd7,  24'h000000, 1, 24'hFFFFC3, 0);
        add(0, 0, 1, SZ_W, 1, 24'd5,  24'h000000, 1, 24'hA1B2C3, 0);
        add(0, 1, 0, SZ_B, 0, 24'd62, 24'h00007E, 0, 24'h000000, 0);
        add(0, 0, 1, SZ_B, 1, 24'd62, 24'h000000, 1, 24'h00007E, 0);
        add(0, 1, 0, SZ_W, 0, 24'd62, 24'h112233, 1, 24'h000000, 1);
        add(0, 1, 0, SZ_B, 0, 24'd63, 24'h000099, 0, 24'h000000, 0);
        add(0, 0, 1, SZ_H, 1, 24'd62, 24'h000000, 1, 24'h007E99, 0);
        add(0, 0, 1, SZ_W, 0, 24'd5,  24'h000000, 1, 24'hA1B2C3, 0);
        add(0, 1, 0, SZ_X, 0, 24'd5,  24'hFFFFFF, 1, 24'h000000, 1);
        add(0, 0, 1, SZ_W, 0, 24'd5,  24'h000000, 1, 24'hA1B2C3, 0);
        add(0, 1, 1, SZ_W, 0, 24'd5,  24'h000000, 1, 24'h000000, 1);
        add(0, 0, 1, SZ_W, 0, 24'd5,  24'h000000, 1, 24'hA1B2C3, 0);
        add(0, 0, 1, SZ_W, 0, 24'd62, 24'h000000, 1, 24'h000000, 1);
        add(0, 0, 1, SZ_W, 0, 24'd5,  24'h000000, 1, 24'hA1B2C3, 0);
        add(0, 0, 1, SZ_H, 0, 24'd63, 24'h000000, 1, 24'h000000, 1);
        add(1, 1, 0, SZ_B, 0, 24'd12, 24'h000056, 0, 24'h000000, 0);
        add(1, 1, 0, SZ_H, 0, 24'd10, 24'hAB1234, 0, 24'h000000, 0);
        add(1, 0, 1, SZ_W, 0, 24'd10, 24'h000000, 1, 24'h561234, 0);
        add(1, 0, 1, SZ_B, 0, 24'd11, 24'h000000, 1, 24'h000012, 0);
        add(1, 0, 1, SZ_H, 0, 24'd11, 24'h000000, 1, 24'h005612, 0);
        add(1, 1, 0, SZ_W, 0, 24'd20, 24'h80FF01, 0, 24'h000000, 0);
        add(1, 0, 1, SZ_H, 0, 24'd21, 24'h000000, 1, 24'hFF80FF, 0);
        add(1, 0, 1, SZ_B, 0, 24'd20, 24'h000000, 1, 24'h000001, 0);
        add(1, 0, 1, SZ_W, 1, 24'd20, 24'h000000, 1, 24'h80FF01, 0);
        add(2, 1, 0, SZ_W, 0, 24'd0,  24'h123456, 0, 24'h000000, 0);
        add(2, 0, 1, SZ_W, 0, 24'd0,  24'h000000, 1, 24'h123456, 0);

        // Done follows WAIT_STATES+1 edges after the accept edge (WAIT cycles plus RESP).
        foreach (v[i]) begin
            access(v[i].d, v[i].w, v[i].r, v[i].sz, v[i].u, v[i].a, v[i].wd, rd, f, lat);
            check($sformatf("v%0d latency", i), lat, (v[i].d == 2) ? 32'd4 : 32'd1);
            check($sformatf("v%0d fault", i), {31'd0, f}, {31'd0, v[i].ef});
            if (v[i].crd) check($sformatf("v%0d rdata", i), {8'd0, rd}, {8'd0, v[i].erd});
        end

        // Req with neither qualifier is a no-op: Ready stays high and no Done follows.
        addr = 24'd5; mr = 1'b0; mw = 1'b0; size = SZ_W; req = 3'b001;
        @(posedge Clock);
        #1;
        req = '0;
        cnt = 0;
        for (int c = 0; c < 3; c++) begin
            if (!rdy[0] || done[0]) cnt++;
            @(posedge Clock);
            #1;
        end
        check("noop stays idle", cnt, 32'd0);

        // Wait-state instance with Req held high: the changed request is taken only once
        // Ready returns, i.e. in the same cycle as the first Done.
        addr = 24'd0; mr = 1'b1; mw = 1'b0; size = SZ_W; uns = 1'b0; req = 3'b100;
        @(posedge Clock);
        #1;
        addr = 24'd2; size = SZ_B; uns = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("ws busy ready c%0d", c), {31'd0, rdy[2]}, 32'd0);
            check($sformatf("ws busy done c%0d", c), {31'd0, done[2]}, 32'd0);
            @(posedge Clock);
            #1;
        end
        check("ws done cycle5", {31'd0, done[2]}, 32'd1);
        check("ws ready cycle5", {31'd0, rdy[2]}, 32'd1);
        check("ws rdata first", {8'd0, rdat[2]}, 32'h123456);
        @(posedge Clock);
        #1;
        req = '0;
        check("ws second accepted", {31'd0, rdy[2]}, 32'd0);
        wait_done(2, lat);
        check("ws second latency", lat, 32'd4);
        check("ws second rdata", {8'd0, rdat[2]}, 32'h000056);

        // Reset during WAIT of a store: immediate idle, no Done, no partial write.
        addr = 24'd0; wdata = 24'h555555; mw = 1'b1; mr = 1'b0; size = SZ_W; req = 3'b100;
        @(posedge Clock);
        #1;
        req = '0;
        @(posedge Clock);
        #1;
        Reset_n = 1'b0;
        #1;
        check("rst mid ready", {31'd0, rdy[2]}, 32'd1);
        check("rst mid done", {31'd0, done[2]}, 32'd0);
        check("rst mid rdata", {8'd0, rdat[2]}, 32'd0);
        #2 Reset_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge Clock);
            #1;
            if (done[2]) cnt++;
        end
        check("rst mid no done", cnt, 32'd0);
        access(2, 1'b0, 1'b1, SZ_W, 1'b0, 24'd0, 24'd0, rd, f, lat);
        check("post rst load", {8'd0, rd}, 32'h123456);
        check("post rst latency", lat, 32'd4);
        access(0, 1'b0, 1'b1, SZ_W, 1'b0, 24'd5, 24'd0, rd, f, lat);
        check("mem kept over reset", {8'd0, rd}, 32'hA1B2C3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
